// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR-to-I2S transmit path.
package fir_pkg;

  typedef enum logic {IDLE, RUN} i2s_state_t;

  localparam int unsigned DEF_SLOT_WIDTH = 32;
  localparam int unsigned I2S_FRAME_BITS = 2 * DEF_SLOT_WIDTH;

  function automatic int unsigned i2s_frame_bits(input int unsigned slot_width);
    return 2 * slot_width;
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// I2S bit-clock divider and frame bit-position counter; both idle at zero when not running.
module i2s_sclk_gen #(
  parameter int unsigned SLOT_WIDTH = 32,
  parameter int unsigned SCLK_DIV   = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            run,
  output logic                            o_sclk,
  output logic                            fall_tick,
  output logic [$clog2(2*SLOT_WIDTH)-1:0] bit_cnt
);
  import fir_pkg::*;

  localparam int unsigned FRAME_BITS = i2s_frame_bits(SLOT_WIDTH);
  localparam int unsigned DIV_W      = $clog2(SCLK_DIV);
  localparam int unsigned BIT_W      = $clog2(2*SLOT_WIDTH);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    fall_tick = run && (div_q == DIV_W'(SCLK_DIV - 1));
    div_d     = '0;
    if (run && !fall_tick) begin
      div_d = div_q + 1'b1;
    end
    bit_d = bit_q;
    if (!run) begin
      bit_d = '0;
    end else if (fall_tick) begin
      bit_d = (bit_q == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_q + 1'b1;
    end
    // Registered from the next divider value so SCLK tracks div_cnt without a cycle of skew.
    sclk_d = (div_d >= DIV_W'(SCLK_DIV / 2));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q  <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      sclk_q <= sclk_d;
    end
  end

  assign o_sclk  = sclk_q;
  assign bit_cnt = bit_q;

endmodule

// File: rtl/fir_i2s_tx.sv
// Stereo I2S master transmitter fed by FIR sample strobes through a one-frame holding buffer.
module fir_i2s_tx
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = 32,
  parameter int unsigned SCLK_DIV   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_clk_fir,
  input  logic [DATA_WIDTH-1:0] i_data_l,
  input  logic [DATA_WIDTH-1:0] i_data_r,
  output logic                  o_sclk,
  output logic                  o_ws,
  output logic                  o_sd,
  output logic                  o_ready,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned FRAME_BITS = i2s_frame_bits(SLOT_WIDTH);
  localparam int unsigned BIT_W      = $clog2(2*SLOT_WIDTH);

  i2s_state_t            state_q, state_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  ws_q, ws_d, sd_q, sd_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  run, fall_tick, boundary, load;
  logic [BIT_W-1:0]      bit_cnt;
  logic [SLOT_WIDTH-1:0] slot_l, slot_r;

  assign run = (state_q == RUN);

  i2s_sclk_gen #(
    .SLOT_WIDTH(SLOT_WIDTH),
    .SCLK_DIV  (SCLK_DIV)
  ) u_sclk_gen (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .run      (run),
    .o_sclk   (o_sclk),
    .fall_tick(fall_tick),
    .bit_cnt  (bit_cnt)
  );

  always_comb begin
    slot_l                              = '0;
    slot_r                              = '0;
    slot_l[SLOT_WIDTH-1 -: DATA_WIDTH]  = buf_l_q;
    slot_r[SLOT_WIDTH-1 -: DATA_WIDTH]  = buf_r_q;
    boundary = fall_tick && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    state_d  = state_q;
    full_d   = full_q;
    buf_l_d  = buf_l_q;
    buf_r_d  = buf_r_q;
    sr_d     = sr_q;
    ws_d     = ws_q;
    sd_d     = sd_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        ws_d = 1'b0;
        sd_d = 1'b0;
        if (i_en && full_q) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (fall_tick) begin
          // The shifter MSB is the next frame bit; o_sd runs one bit behind o_ws.
          sd_d = sr_q[FRAME_BITS-1];
          sr_d = sr_q << 1;
          ws_d = !boundary && (bit_cnt >= BIT_W'(SLOT_WIDTH - 1));
        end
        if (boundary) begin
          if (!i_en) begin
            state_d = IDLE;
            ws_d    = 1'b0;
            sd_d    = 1'b0;
          end else if (full_q) begin
            load = 1'b1;
          end else begin
            sr_d  = '0;
            unf_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sr_d = {slot_l, slot_r};
    end

    if (i_clk_fir) begin
      if (!full_q || load) begin
        buf_l_d = i_data_l;
        buf_r_d = i_data_r;
        full_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (load) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      full_q  <= 1'b0;
      buf_l_q <= '0;
      buf_r_q <= '0;
      sr_q    <= '0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      sr_q    <= sr_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_ws        = ws_q;
  assign o_sd        = sd_q;
  assign o_ready     = !full_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_fir_i2s_tx.sv
// Scoreboard bench: a frame-level model queues expected frames; a monitor decodes the I2S stream.
module tb_fir_i2s_tx;

  localparam int unsigned DW   = 24;
  localparam int unsigned SW   = 32;
  localparam int unsigned DIV  = 4;
  localparam int unsigned FB   = 2 * SW;
  localparam int          FCYC = FB * DIV;

  logic          clk = 1'b0;
  logic          i_rst, i_en, i_clk_fir;
  logic [DW-1:0] i_data_l, i_data_r;
  logic          o_sclk, o_ws, o_sd, o_ready, o_overflow, o_underflow;

  always #5 clk = ~clk;

  fir_i2s_tx #(
    .DATA_WIDTH(DW),
    .SLOT_WIDTH(SW),
    .SCLK_DIV  (DIV)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_clk_fir  (i_clk_fir),
    .i_data_l   (i_data_l),
    .i_data_r   (i_data_r),
    .o_sclk     (o_sclk),
    .o_ws       (o_ws),
    .o_sd       (o_sd),
    .o_ready    (o_ready),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow)
  );

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } frame_t;

  frame_t        exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            en = 1'b0;
  bit            m_full = 1'b0, m_run = 1'b0;
  logic [DW-1:0] m_l = '0, m_r = '0;
  int            m_cyc = 0, m_frames = 0;
  bit            exp_ovf = 1'b0, exp_unf = 1'b0, exp_ready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model decides what the coming edge does at frame level.
  task automatic tick(input bit stb, input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit     load, ovf, unf;
    frame_t f;
    i_en      = en;
    i_clk_fir = stb;
    i_data_l  = l;
    i_data_r  = r;
    load = 1'b0;
    ovf  = 1'b0;
    unf  = 1'b0;
    if (!m_run) begin
      if (en && m_full) begin
        load  = 1'b1;
        m_run = 1'b1;
        m_cyc = 0;
      end
    end else if (m_cyc == FCYC - 1) begin
      m_cyc = 0;
      if (!en) begin
        m_run = 1'b0;
      end else if (m_full) begin
        load = 1'b1;
      end else begin
        unf = 1'b1;
        f.l = '0;
        f.r = '0;
        exp_q.push_back(f);
        m_frames++;
      end
    end else begin
      m_cyc++;
    end
    if (load) begin
      f.l = m_l;
      f.r = m_r;
      exp_q.push_back(f);
      m_frames++;
    end
    if (stb) begin
      if (!m_full || load) begin
        m_l    = l;
        m_r    = r;
        m_full = 1'b1;
      end else begin
        ovf = 1'b1;
      end
    end else if (load) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_ovf   = ovf;
    exp_unf   = unf;
    exp_ready = !m_full;
    i_clk_fir = 1'b0;
  endtask

  task automatic wait_at(input int frame, input int cyc);
    int n = 0;
    while (!(m_run && m_frames == frame && m_cyc == cyc) && n < 4 * FCYC) begin
      tick(1'b0, '0, '0);
      n++;
    end
    if (n >= 4 * FCYC) begin
      checks++;
      errors++;
      $display("FAIL wait_at frame=%0d cyc=%0d timed out", frame, cyc);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_run && n < 2 * FCYC) begin
      tick(1'b0, '0, '0);
      n++;
    end
    if (m_run) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timed out");
    end
    repeat (20) tick(1'b0, '0, '0);
  endtask

  // Monitor: sample the serial line on SCLK rises; rise r has slot position r mod FB.
  int          rise = 0, low = 0;
  bit          prev_sclk = 1'b0, ws_bad = 1'b0;
  logic [FB-1:0] fb = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (i_rst) begin
        rise      = 0;
        low       = 0;
        prev_sclk = 1'b0;
        ws_bad    = 1'b0;
      end else begin
        check("ready", {63'd0, o_ready}, {63'd0, exp_ready});
        if (o_overflow || exp_ovf) check("overflow", {63'd0, o_overflow}, {63'd0, exp_ovf});
        if (o_underflow || exp_unf) check("underflow", {63'd0, o_underflow}, {63'd0, exp_unf});
        if (o_sclk && !prev_sclk) begin
          int p;
          p = rise % FB;
          if (o_ws !== (p >= SW)) ws_bad = 1'b1;
          if (p >= 1) fb[p-1] = o_sd;
          if (p == FB - 1) begin
            logic [DW-1:0] obs_l, obs_r;
            frame_t        f;
            for (int k = 0; k < DW; k++) begin
              obs_l[DW-1-k] = fb[k];
              obs_r[DW-1-k] = fb[SW+k];
            end
            check("ws_pattern", {63'd0, ws_bad}, 64'd0);
            ws_bad = 1'b0;
            check("pad_zero", {48'd0, fb[SW-1:DW], fb[FB-2:SW+DW]}, 64'd0);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame l=%0h r=%0h", obs_l, obs_r);
            end else begin
              f = exp_q.pop_front();
              check("frame_left", {40'd0, obs_l}, {40'd0, f.l});
              check("frame_right", {40'd0, obs_r}, {40'd0, f.r});
            end
          end
          rise++;
          low = 0;
        end else if (!o_sclk) begin
          low++;
          if (low >= 2 * DIV) rise = 0;
        end
        prev_sclk = o_sclk;
      end
    end
  end

  initial begin
    i_rst     = 1'b1;
    i_en      = 1'b0;
    i_clk_fir = 1'b0;
    i_data_l  = '0;
    i_data_r  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", {63'd0, o_sclk}, 64'd0);
    check("rst_ws", {63'd0, o_ws}, 64'd0);
    check("rst_sd", {63'd0, o_sd}, 64'd0);
    check("rst_ready", {63'd0, o_ready}, 64'd1);
    check("rst_ovf", {63'd0, o_overflow}, 64'd0);
    check("rst_unf", {63'd0, o_underflow}, 64'd0);
    i_rst = 1'b0;

    // First frame, then an underflow frame of zeros.
    en = 1'b1;
    tick(1'b1, 24'h800001, 24'h7FFFFE);
    wait_at(2, 20);
    // Two strobes ten cycles apart within one frame: second is dropped.
    tick(1'b1, 24'h123456, 24'hABCDEF);
    repeat (9) tick(1'b0, '0, '0);
    tick(1'b1, 24'h0F0F0F, 24'hF0F0F0);
    // Strobe on the exact load edge while full.
    wait_at(3, 30);
    tick(1'b1, 24'hC0FFEE, 24'h5A5A5A);
    wait_at(3, FCYC - 1);
    tick(1'b1, 24'h3C3C3C, 24'hDEAD01);
    // Drop enable mid-frame.
    wait_at(5, 10 * DIV);
    en = 1'b0;
    wait_idle();
    check("idle_sclk", {63'd0, o_sclk}, 64'd0);
    check("idle_ws", {63'd0, o_ws}, 64'd0);
    check("idle_sd", {63'd0, o_sd}, 64'd0);

    // Asynchronous reset in the middle of a frame.
    en = 1'b1;
    tick(1'b1, 24'h111111, 24'h222222);
    wait_at(6, 40 * DIV);
    i_rst = 1'b1;
    #1;
    check("arst_sclk", {63'd0, o_sclk}, 64'd0);
    check("arst_ws", {63'd0, o_ws}, 64'd0);
    check("arst_sd", {63'd0, o_sd}, 64'd0);
    check("arst_ready", {63'd0, o_ready}, 64'd1);
    check("arst_ovf", {63'd0, o_overflow}, 64'd0);
    check("arst_unf", {63'd0, o_underflow}, 64'd0);
    m_full    = 1'b0;
    m_run     = 1'b0;
    m_cyc     = 0;
    m_frames  = 0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    exp_ready = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    repeat (4) tick(1'b0, '0, '0);
    tick(1'b1, 24'h654321, 24'h9ABCDE);
    wait_at(2, 5);

    // Random traffic: strobe rate chosen to mix overflow, underflow and clean frames.
    for (int i = 0; i < 8 * FCYC; i++) begin
      tick(($urandom_range(0, 149) == 0), DW'($urandom), DW'($urandom));
    end
    en = 1'b0;
    wait_idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
